// File: rtl/dst_stream_out_pkg.sv
// Shared defaults and FSM state encoding for the destination-buffer stream drain.
package dst_stream_out_pkg;

   localparam int AW_DEF    = 12;
   localparam int DW_DEF    = 32;
   localparam int DEPTH_DEF = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/dst_stream_out_if.sv
// AXI-Stream style beat interface (valid/data/last/ready) between the drain stage and its consumer.
interface dst_stream_out_if
   import dst_stream_out_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          valid;
   logic [DW-1:0] data;
   logic          last;
   logic          ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dst_stream_out_sync_fifo.sv
// Small synchronous FIFO with occupancy count; read data is the head entry (show-ahead).
module sync_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Callers own flow control; these only flag a broken credit scheme.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/dst_stream_out.sv
// Drains len words from the dst buffer (1-cycle read latency) onto a back-pressured stream with TLAST.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; len==0 start just pulses done
//   ST_RUN   | issuing buffer reads while words remain and FIFO credit exists
//   ST_DRAIN | all reads issued; waiting for the last beat to be accepted
module dst_stream_out
   import dst_stream_out_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    len,
   output logic             busy,
   output logic             done,
   output logic             buf_re,
   output logic [AW-1:0]    buf_a,
   input  logic [DW-1:0]    buf_d,
   dst_stream_out_if.master m
);
   localparam int CW = $clog2(DEPTH);

   state_t        state;
   logic [AW-1:0] len_q;
   logic [AW-1:0] rc;
   logic [AW-1:0] sc;
   logic [AW-1:0] addr_q;
   logic          inflight;

   logic          issue;
   logic          credit_ok;
   logic          pop;
   logic          finish;
   logic [CW:0]   occupancy;

   logic [DW:0]   fifo_wdata;
   logic [DW:0]   fifo_rdata;
   logic [CW:0]   fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   // A read in flight already owns a FIFO slot, so it counts against credit.
   assign occupancy = fifo_count + {{CW{1'b0}}, inflight};
   assign credit_ok = !fifo_full && (occupancy < (CW+1)'(DEPTH));
   assign issue     = (state == ST_RUN) && (rc < len_q) && credit_ok;

   assign buf_re = issue;
   assign buf_a  = rc;
   assign busy   = (state != ST_IDLE);

   assign fifo_wdata = {(addr_q == len_q - AW'(1)), buf_d};

   assign m.valid = !fifo_empty;
   assign m.data  = fifo_rdata[DW-1:0];
   assign m.last  = fifo_rdata[DW];

   assign pop    = m.valid && m.ready;
   assign finish = busy && pop && (sc == len_q - AW'(1));

   sync_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         len_q    <= '0;
         rc       <= '0;
         sc       <= '0;
         addr_q   <= '0;
         inflight <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            addr_q <= rc;
            rc     <= rc + AW'(1);
         end
         if (pop) sc <= sc + AW'(1);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     len_q <= len;
                     rc    <= '0;
                     sc    <= '0;
                     state <= ST_RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (finish) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else if (rc == len_q) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (finish) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dst_stream_out.sv
// Bench for dst_stream_out: table of directed transfers, reset/restart corners, and random transfers.
module tb_dst_stream_out;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] len;
   logic          busy;
   logic          done;
   logic          buf_re;
   logic [AW-1:0] buf_a;
   logic [DW-1:0] buf_d;

   dst_stream_out_if #(.DW(DW)) m_if ();

   dst_stream_out #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .len    (len),
      .busy   (busy),
      .done   (done),
      .buf_re (buf_re),
      .buf_a  (buf_a),
      .buf_d  (buf_d),
      .m      (m_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Destination buffer: registered read, one cycle latency.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (buf_re) buf_d <= mem[buf_a];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: the words a transfer must deliver, in order; the last one carries TLAST.
   logic [DW-1:0] exp_q [$];

   bit            mon_en = 1'b0;
   int            t0, mon_rel;
   int            rd_cnt, rd_early, beat_cnt, data_err, addr_err, stab_err;
   int            done_cnt, done_cyc, first_cyc, valid_cyc, max_out;
   logic          busy1, busy_done, stall_prev, prev_last;
   logic [DW-1:0] prev_data;

   always @(negedge clk) begin
      if (mon_en) begin
         mon_rel = cyc - t0;
         if (mon_rel == 1) busy1 = busy;
         if (buf_re) begin
            if (buf_a != AW'(rd_cnt)) addr_err++;
            rd_cnt++;
            if (mon_rel < 20) rd_early++;
         end
         if (rd_cnt - beat_cnt > max_out) max_out = rd_cnt - beat_cnt;
         if (m_if.valid) valid_cyc++;
         if (stall_prev && (!m_if.valid || m_if.data !== prev_data || m_if.last !== prev_last))
            stab_err++;
         stall_prev = m_if.valid && !m_if.ready;
         prev_data  = m_if.data;
         prev_last  = m_if.last;
         if (m_if.valid && m_if.ready) begin
            if (beat_cnt == 0) first_cyc = mon_rel;
            if (beat_cnt >= exp_q.size()) data_err++;
            else if (m_if.data !== exp_q[beat_cnt] ||
                     m_if.last !== (beat_cnt == exp_q.size() - 1)) data_err++;
            beat_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc  = mon_rel;
            busy_done = busy;
         end
      end
   end

   function automatic logic ready_for(input int mode, input int rel);
      case (mode)
         0:       return 1'b1;
         1:       return (rel % 2) == 0;
         2:       return rel >= 20;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   task automatic clear_mon();
      rd_cnt = 0; rd_early = 0; beat_cnt = 0; data_err = 0; addr_err = 0; stab_err = 0;
      done_cnt = 0; done_cyc = -1; first_cyc = -1; valid_cyc = 0; max_out = 0;
      busy1 = 1'b0; busy_done = 1'b0; stall_prev = 1'b0;
   endtask

   task automatic load_words(input int n, input bit randmem);
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         mem[k] = randmem ? DW'($urandom) : DW'(32'h100 + k);
         exp_q.push_back(mem[k]);
      end
   endtask

   task automatic run_xfer(input string tag, input int n, input int mode, input bit randmem,
                           input bit restart, input int exp_first, input int exp_done);
      int rel;
      load_words(n, randmem);
      clear_mon();
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b1;
      len = AW'(n);
      m_if.ready = ready_for(mode, 0);
      mon_en = 1'b1;
      rel = 0;
      while (done_cnt == 0 && rel < 400) begin
         @(posedge clk); #1;
         rel++;
         start = restart && (rel == 2);
         len = start ? AW'(7) : AW'(n);
         m_if.ready = ready_for(mode, rel);
      end
      repeat (6) begin
         @(posedge clk); #1;
         start = 1'b0;
         m_if.ready = 1'b1;
      end
      @(posedge clk); #1;
      mon_en = 1'b0;
      check({tag, " beats"},      beat_cnt, n);
      check({tag, " data/last"},  data_err, 0);
      check({tag, " reads"},      rd_cnt, n);
      check({tag, " read addr"},  addr_err, 0);
      check({tag, " done count"}, done_cnt, 1);
      check({tag, " busy@done"},  int'(busy_done), 0);
      check({tag, " stable"},     stab_err, 0);
      check({tag, " occupancy"},  int'(max_out <= DEPTH), 1);
      check({tag, " busy@1"},     int'(busy1), int'(n != 0));
      if (n == 0) check({tag, " valid cycles"}, valid_cyc, 0);
      if (exp_first >= 0) check({tag, " first beat cyc"}, first_cyc, exp_first);
      if (exp_done >= 0) check({tag, " done cyc"}, done_cyc, exp_done);
      if (mode == 2) check({tag, " reads while stalled"}, rd_early, DEPTH);
   endtask

   typedef struct {
      int n;
      int mode;
      bit restart;
      int exp_first;
      int exp_done;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{n: 5,  mode: 0, restart: 0, exp_first: 3,  exp_done: 8};
      vecs[1] = '{n: 8,  mode: 1, restart: 0, exp_first: -1, exp_done: -1};
      vecs[2] = '{n: 6,  mode: 2, restart: 0, exp_first: 20, exp_done: 26};
      vecs[3] = '{n: 0,  mode: 0, restart: 0, exp_first: -1, exp_done: 1};
      vecs[4] = '{n: 1,  mode: 0, restart: 1, exp_first: 3,  exp_done: 4};
      vecs[5] = '{n: 3,  mode: 0, restart: 0, exp_first: 3,  exp_done: 6};
      vecs[6] = '{n: 12, mode: 0, restart: 0, exp_first: 3,  exp_done: 15};
      vecs[7] = '{n: 4,  mode: 1, restart: 0, exp_first: -1, exp_done: -1};

      rst = 1'b1;
      start = 1'b0;
      len = '0;
      m_if.ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy",   int'(busy), 0);
      check("reset done",   int'(done), 0);
      check("reset buf_re", int'(buf_re), 0);
      check("reset buf_a",  int'(buf_a), 0);
      check("reset valid",  int'(m_if.valid), 0);
      check("reset last",   int'(m_if.last), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run_xfer($sformatf("vec%0d", i), vecs[i].n, vecs[i].mode, 1'b0,
                  vecs[i].restart, vecs[i].exp_first, vecs[i].exp_done);

      // Reset in cycle 5 of a 10-word transfer abandons it without done.
      load_words(10, 1'b0);
      clear_mon();
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b1;
      len = AW'(10);
      m_if.ready = 1'b1;
      mon_en = 1'b1;
      for (int r = 1; r <= 5; r++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst mid valid", int'(m_if.valid), 0);
      check("rst mid busy",  int'(busy), 0);
      check("rst mid done",  int'(done), 0);
      repeat (8) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("rst mid no done", done_cnt, 0);
      check("rst mid beats before reset", beat_cnt, 3);
      run_xfer("after rst", 2, 0, 1'b0, 1'b0, 3, 5);

      for (int i = 0; i < 12; i++) begin
         int n, mode;
         n = $urandom_range(1, 40);
         mode = (i % 3 == 0) ? 0 : 3;
         run_xfer($sformatf("rand%0d", i), n, mode, 1'b1, 1'b0,
                  (mode == 0) ? 3 : -1, (mode == 0) ? 3 + n : -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
